// File: rtl/clk_phase_monitor.sv
// Checks that {clk_25K, clk_50K, clk_100K} sampled on clk_200K counts up by one per edge; reports lock, error pulses and a saturating error count.
// Define CLK_PHASE_STICKY_EN to add err_clr / err_sticky (sticky error flag with clear).
module clk_phase_monitor #(
  parameter int unsigned LOCK_COUNT = 8,
  parameter int unsigned ERR_W      = 8
) (
  input  logic             clk_200K,
  input  logic             rst,
  input  logic             clk_100K,
  input  logic             clk_50K,
  input  logic             clk_25K,
`ifdef CLK_PHASE_STICKY_EN
  input  logic             err_clr,
  output logic             err_sticky,
`endif
  output logic             locked,
  output logic             phase_err,
  output logic [ERR_W-1:0] err_cnt,
  output logic [2:0]       phase_idx
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACQUIRE,
    ST_LOCKED
  } state_t;

  localparam logic [7:0]       LOCK_LAST = 8'(LOCK_COUNT - 1);
  localparam logic [ERR_W-1:0] CNT_MAX   = '1;

  state_t           state_q, state_d;
  logic [2:0]       prev_q, prev_d;
  logic [7:0]       good_q, good_d;
  logic             locked_q, locked_d;
  logic             perr_q, perr_d;
  logic [ERR_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;

  logic [2:0] samp;
  logic [2:0] prev_inc;
  logic       match;

  assign samp     = {clk_25K, clk_50K, clk_100K};
  assign prev_inc = prev_q + 3'd1;
  assign match    = (samp == prev_inc);

  always_comb begin
    state_d  = state_q;
    prev_d   = samp;
    good_d   = good_q;
    locked_d = locked_q;
    perr_d   = 1'b0;
    cnt_d    = cnt_q;
    idx_d    = samp;

    unique case (state_q)
      ST_IDLE: begin
        // First sample after reset has no predecessor to compare against.
        good_d  = 8'd0;
        state_d = ST_ACQUIRE;
      end
      ST_ACQUIRE: begin
        if (match) begin
          if (good_q == LOCK_LAST) begin
            state_d  = ST_LOCKED;
            locked_d = 1'b1;
            good_d   = 8'd0;
          end else begin
            good_d = good_q + 8'd1;
          end
        end else begin
          good_d = 8'd0;
        end
      end
      ST_LOCKED: begin
        if (!match) begin
          perr_d   = 1'b1;
          locked_d = 1'b0;
          good_d   = 8'd0;
          state_d  = ST_ACQUIRE;
          if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + ERR_W'(1);
          end
        end
      end
      default: begin
        state_d  = ST_IDLE;
        locked_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_200K) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      prev_q   <= 3'd0;
      good_q   <= 8'd0;
      locked_q <= 1'b0;
      perr_q   <= 1'b0;
      cnt_q    <= '0;
      idx_q    <= 3'd0;
    end else begin
      state_q  <= state_d;
      prev_q   <= prev_d;
      good_q   <= good_d;
      locked_q <= locked_d;
      perr_q   <= perr_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
    end
  end

  assign locked    = locked_q;
  assign phase_err = perr_q;
  assign err_cnt   = cnt_q;
  assign phase_idx = idx_q;

`ifdef CLK_PHASE_STICKY_EN
  logic sticky_q, sticky_d;

  // A new error on the same edge as a clear request keeps the flag set.
  always_comb begin
    sticky_d = sticky_q;
    if (perr_d) begin
      sticky_d = 1'b1;
    end else if (err_clr) begin
      sticky_d = 1'b0;
    end
  end

  always_ff @(posedge clk_200K) begin
    if (rst) begin
      sticky_q <= 1'b0;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  assign err_sticky = sticky_q;
`endif

endmodule

// File: tb/tb_clk_phase_monitor.sv
// Scoreboard bench for clk_phase_monitor: stimulus pushes expected outputs per edge, a monitor pops and compares on the falling edge.
`timescale 1ns/1ps
module tb_clk_phase_monitor;

  localparam int LOCK = 8;

  typedef struct {
    logic       lk;
    logic       pe;
    logic [7:0] cnt;
    logic [1:0] cnt2;
    logic [2:0] idx;
    logic       sticky;
  } exp_t;

  logic clk_200K = 1'b0;
  logic rst = 1'b1;
  logic clk_100K = 1'b0;
  logic clk_50K = 1'b0;
  logic clk_25K = 1'b0;
  logic err_clr = 1'b0;

  logic       a_locked, a_perr;
  logic [7:0] a_cnt;
  logic [2:0] a_idx;
  logic       b_locked, b_perr;
  logic [1:0] b_cnt;
  logic [2:0] b_idx;
`ifdef CLK_PHASE_STICKY_EN
  logic a_sticky, b_sticky;
`endif

  clk_phase_monitor #(.LOCK_COUNT(LOCK), .ERR_W(8)) u_dut_a (
    .clk_200K (clk_200K),
    .rst      (rst),
    .clk_100K (clk_100K),
    .clk_50K  (clk_50K),
    .clk_25K  (clk_25K),
`ifdef CLK_PHASE_STICKY_EN
    .err_clr  (err_clr),
    .err_sticky(a_sticky),
`endif
    .locked   (a_locked),
    .phase_err(a_perr),
    .err_cnt  (a_cnt),
    .phase_idx(a_idx)
  );

  clk_phase_monitor #(.LOCK_COUNT(LOCK), .ERR_W(2)) u_dut_b (
    .clk_200K (clk_200K),
    .rst      (rst),
    .clk_100K (clk_100K),
    .clk_50K  (clk_50K),
    .clk_25K  (clk_25K),
`ifdef CLK_PHASE_STICKY_EN
    .err_clr  (err_clr),
    .err_sticky(b_sticky),
`endif
    .locked   (b_locked),
    .phase_err(b_perr),
    .err_cnt  (b_cnt),
    .phase_idx(b_idx)
  );

  always #2500 clk_200K = ~clk_200K;

  exp_t       exp_q[$];
  int         n_checks = 0;
  int         n_fail = 0;
  int         exp_cnt = 0;
  logic       exp_sticky = 1'b0;
  logic [2:0] cur_s = 3'd0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h, expected %0h", nm, $time, act, req);
    end
  endtask

  // Monitor: DUT outputs are valid after every edge; compare on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_200K);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("a_locked",    32'(a_locked), 32'(e.lk));
        chk("a_phase_err", 32'(a_perr),   32'(e.pe));
        chk("a_err_cnt",   32'(a_cnt),    32'(e.cnt));
        chk("a_phase_idx", 32'(a_idx),    32'(e.idx));
        chk("b_locked",    32'(b_locked), 32'(e.lk));
        chk("b_phase_err", 32'(b_perr),   32'(e.pe));
        chk("b_err_cnt",   32'(b_cnt),    32'(e.cnt2));
`ifdef CLK_PHASE_STICKY_EN
        chk("a_err_sticky", 32'(a_sticky), 32'(e.sticky));
        chk("b_err_sticky", 32'(b_sticky), 32'(e.sticky));
`endif
      end
    end
  end

  // One clk_200K edge: drive, clock, then queue what the outputs must be after that edge.
  task automatic step(input logic [2:0] sv, input logic r, input logic clr,
                      input logic exp_lk, input logic exp_pe);
    exp_t e;
    {clk_25K, clk_50K, clk_100K} = sv;
    rst = r;
    err_clr = clr;
    @(posedge clk_200K);
    if (r) begin
      exp_cnt = 0;
      exp_sticky = 1'b0;
    end else if (exp_pe) begin
      exp_cnt++;
      exp_sticky = 1'b1;
    end else if (clr) begin
      exp_sticky = 1'b0;
    end
    e.lk = exp_lk;
    e.pe = exp_pe;
    e.cnt = 8'(exp_cnt);
    e.cnt2 = (exp_cnt > 3) ? 2'd3 : 2'(exp_cnt);
    e.idx = r ? 3'd0 : sv;
    e.sticky = exp_sticky;
    exp_q.push_back(e);
    #1;
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) step(cur_s, 1'b1, 1'b0, 1'b0, 1'b0);
    cur_s = 3'd0;
  endtask

  // After reset (first edge is capture only) or a glitch (first edge mismatches),
  // LOCK further matches are needed, so locked is high from edge LOCK+1 onward.
  task automatic run_ideal(input int n);
    for (int i = 1; i <= n; i++) begin
      step(cur_s, 1'b0, 1'b0, (i >= LOCK + 1), 1'b0);
      cur_s = cur_s + 3'd1;
    end
  endtask

  // Invert clk_50K for one sample while locked.
  task automatic glitch(input logic clr);
    step(cur_s ^ 3'b010, 1'b0, clr, 1'b0, 1'b1);
    cur_s = cur_s + 3'd1;
  endtask

  initial begin
    #(64'd100000 * 64'd5000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset(2);
    run_ideal(12);
    glitch(1'b0);
    run_ideal(12);
    glitch(1'b0);
    run_ideal(12);

    // Reset mid-lock with err_cnt=2, then relock.
    do_reset(1);
    run_ideal(12);

    // Stuck inputs never lock and never count errors.
    do_reset(1);
    repeat (50) step(3'b000, 1'b0, 1'b0, 1'b0, 1'b0);

    // Saturation on the ERR_W=2 instance: 1,2,3,3,3.
    do_reset(1);
    run_ideal(10);
    repeat (5) begin
      glitch(1'b0);
      run_ideal(10);
    end

`ifdef CLK_PHASE_STICKY_EN
    do_reset(1);
    run_ideal(10);
    glitch(1'b0);
    run_ideal(20);
    step(cur_s, 1'b0, 1'b1, 1'b1, 1'b0);
    cur_s = cur_s + 3'd1;
    run_ideal(3);
    glitch(1'b1);
    run_ideal(10);
`endif

    err_clr = 1'b0;
    @(negedge clk_200K);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
